// File: rtl/ext_arbiter_if.sv
// Request/result bundle of the shared immediate-extension unit.
// The arbiter connects through the slave modport; requesters and the consumer use master.
interface ext_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [15:0] req0_imm;
  logic [1:0]  req0_eop;
  logic        req1_valid;
  logic        req1_ready;
  logic [15:0] req1_imm;
  logic [1:0]  req1_eop;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_id;

  modport slave (
    input  req0_valid, req0_imm, req0_eop,
    input  req1_valid, req1_imm, req1_eop,
    input  res_ready,
    output req0_ready, req1_ready,
    output res_valid, res_data, res_id
  );

  modport master (
    output req0_valid, req0_imm, req0_eop,
    output req1_valid, req1_imm, req1_eop,
    output res_ready,
    input  req0_ready, req1_ready,
    input  res_valid, res_data, res_id
  );
endinterface

// File: rtl/ext_arbiter.sv
// Round-robin arbiter sharing one immediate-extension unit between decode (port 0) and
// branch-offset (port 1), with a single registered result stage. EXT_ARB_STATS_EN adds counters.
module ext_arbiter #(
  parameter int CNT_W     = 16,
  parameter bit PRIO_INIT = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  ext_arbiter_if.slave      bus
`ifdef EXT_ARB_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [CNT_W-1:0]  stat_grant0,
  output logic [CNT_W-1:0]  stat_grant1,
  output logic [CNT_W-1:0]  stat_stall
`endif
);

  function automatic logic [31:0] ext_imm(input logic [15:0] imm, input logic [1:0] eop);
    logic signed [15:0] simm;
    logic signed [31:0] sext;
    simm = $signed(imm);
    sext = 32'(simm);
    case (eop)
      2'b00:   return sext;
      2'b01:   return {16'h0000, imm};
      2'b10:   return {imm, 16'h0000};
      default: return sext <<< 2;
    endcase
  endfunction

  logic        res_valid_q, res_valid_d;
  logic [31:0] res_data_q,  res_data_d;
  logic        res_id_q,    res_id_d;
  logic        prio_q,      prio_d;

  logic can_accept;
  logic grant0, grant1;
  logic fire0, fire1;

  // prio_q names the requester that wins when both are valid
  assign can_accept = !res_valid_q || bus.res_ready;
  assign grant0     = bus.req0_valid && (!bus.req1_valid || !prio_q);
  assign grant1     = bus.req1_valid && (!bus.req0_valid ||  prio_q);
  assign fire0      = reset && can_accept && grant0;
  assign fire1      = reset && can_accept && grant1;

  assign bus.req0_ready = fire0;
  assign bus.req1_ready = fire1;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_data   = res_data_q;
  assign bus.res_id     = res_id_q;

  always_comb begin
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
    prio_d      = prio_q;
    if (fire0) begin
      res_valid_d = 1'b1;
      res_data_d  = ext_imm(bus.req0_imm, bus.req0_eop);
      res_id_d    = 1'b0;
      prio_d      = 1'b1;
    end else if (fire1) begin
      res_valid_d = 1'b1;
      res_data_d  = ext_imm(bus.req1_imm, bus.req1_eop);
      res_id_d    = 1'b1;
      prio_d      = 1'b0;
    end else if (bus.res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_valid_q <= 1'b0;
      res_data_q  <= 32'h0;
      res_id_q    <= 1'b0;
      prio_q      <= PRIO_INIT;
    end else begin
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
      prio_q      <= prio_d;
    end
  end

`ifdef EXT_ARB_STATS_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [CNT_W-1:0] grant0_cnt_q, grant1_cnt_q, stall_cnt_q;
  logic             stall;

  assign stall = res_valid_q && !bus.res_ready;

  // Clear takes precedence over any count event in the same cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant0_cnt_q <= '0;
      grant1_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else if (stat_clr) begin
      grant0_cnt_q <= '0;
      grant1_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      if (fire0) grant0_cnt_q <= sat_inc(grant0_cnt_q);
      if (fire1) grant1_cnt_q <= sat_inc(grant1_cnt_q);
      if (stall) stall_cnt_q  <= sat_inc(stall_cnt_q);
    end
  end

  assign stat_grant0 = grant0_cnt_q;
  assign stat_grant1 = grant1_cnt_q;
  assign stat_stall  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ext_arbiter.sv
// Scoreboard bench for ext_arbiter: directed requests push expected results, a monitor
// pops and compares each consumed result. Stats checks run when EXT_ARB_STATS_EN is defined.
module tb_ext_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ext_arbiter_if bus();

`ifdef EXT_ARB_STATS_EN
  logic       stat_clr;
  logic [1:0] stat_grant0, stat_grant1, stat_stall;
`endif

  ext_arbiter #(.CNT_W(2), .PRIO_INIT(1'b0)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus)
`ifdef EXT_ARB_STATS_EN
    ,
    .stat_clr   (stat_clr),
    .stat_grant0(stat_grant0),
    .stat_grant1(stat_grant1),
    .stat_stall (stat_stall)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic [32:0] expq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  // Monitor: every consumed result must match the oldest expectation
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (reset && bus.res_valid && bus.res_ready) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mon_unexpected actual=%h required=none", bus.res_data);
        end else begin
          e = expq.pop_front();
          chk("mon_data", bus.res_data, e[31:0]);
          chk1("mon_id", bus.res_id, e[32]);
        end
      end
    end
  end

  task automatic send(input bit port, input logic [15:0] imm, input logic [1:0] eop,
                      input logic [31:0] exp);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    if (port) begin
      bus.req1_valid = 1'b1; bus.req1_imm = imm; bus.req1_eop = eop;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_imm = imm; bus.req0_eop = eop;
    end
    expq.push_back({port, exp});
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (port ? bus.req1_ready : bus.req0_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk1("send_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(negedge clk);
    chk1("latency_valid", bus.res_valid, 1'b1);
  endtask

  logic [32:0] alt_exp [4];

  initial begin
    alt_exp[0] = {1'b0, 32'h00000011};
    alt_exp[1] = {1'b1, 32'h00330000};
    alt_exp[2] = {1'b0, 32'h00000022};
    alt_exp[3] = {1'b1, 32'h80440000};

    bus.req0_valid = 1'b1; bus.req0_imm = 16'h0; bus.req0_eop = 2'b00;
    bus.req1_valid = 1'b0; bus.req1_imm = 16'h0; bus.req1_eop = 2'b00;
    bus.res_ready  = 1'b1;
`ifdef EXT_ARB_STATS_EN
    stat_clr = 1'b0;
`endif

    // Reset state, with a request pending that must not be accepted
    repeat (2) @(negedge clk);
    chk1("rst_valid", bus.res_valid, 1'b0);
    chk("rst_data", bus.res_data, 32'h0);
    chk1("rst_id", bus.res_id, 1'b0);
    chk1("rst_ready0", bus.req0_ready, 1'b0);
    bus.req0_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;

    // Extension ops
    send(1'b0, 16'hffff, 2'b01, 32'h0000ffff);
    send(1'b0, 16'hffff, 2'b00, 32'hffffffff);
    send(1'b1, 16'h7fff, 2'b10, 32'h7fff0000);
    send(1'b1, 16'hffff, 2'b11, 32'hfffffffc);
    send(1'b0, 16'h8000, 2'b00, 32'hffff8000);
    send(1'b1, 16'h1234, 2'b01, 32'h00001234);
    send(1'b0, 16'h0001, 2'b11, 32'h00000004);
    send(1'b1, 16'h8000, 2'b11, 32'hfffe0000);
    repeat (2) @(posedge clk);

    // Contention: pointer is 0, grants must alternate with no bubble
    #1;
    bus.req0_valid = 1'b1; bus.req0_imm = 16'h0011; bus.req0_eop = 2'b01;
    bus.req1_valid = 1'b1; bus.req1_imm = 16'h0033; bus.req1_eop = 2'b10;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k > 0) chk1("alt_res_valid", bus.res_valid, 1'b1);
      chk1("alt_ready0", bus.req0_ready, (k % 2) == 0);
      chk1("alt_ready1", bus.req1_ready, (k % 2) == 1);
      expq.push_back(alt_exp[k]);
      @(posedge clk); #1;
      if (k == 0) bus.req0_imm = 16'h0022;
      if (k == 1) bus.req1_imm = 16'h8044;
      if (k == 2) bus.req0_imm = 16'h0099;
      if (k == 3) begin
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
      end
    end
    @(negedge clk);
    chk1("alt_last_valid", bus.res_valid, 1'b1);
    repeat (2) @(posedge clk);

    // Stall for 3 cycles, then drain and accept in the same cycle
    #1;
    bus.res_ready = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_imm = 16'h00a5; bus.req0_eop = 2'b00;
    expq.push_back({1'b0, 32'h000000a5});
    @(negedge clk);
    chk1("stall_fire", bus.req0_ready, 1'b1);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_imm = 16'hf00d; bus.req1_eop = 2'b00;
    repeat (3) begin
      @(negedge clk);
      chk1("stall_valid", bus.res_valid, 1'b1);
      chk("stall_data", bus.res_data, 32'h000000a5);
      chk1("stall_id", bus.res_id, 1'b0);
      chk1("stall_ready0", bus.req0_ready, 1'b0);
      chk1("stall_ready1", bus.req1_ready, 1'b0);
    end
    @(posedge clk); #1;
    bus.res_ready = 1'b1;
    @(negedge clk);
    chk1("drain_accept", bus.req1_ready, 1'b1);
    expq.push_back({1'b1, 32'hfffff00d});
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    @(negedge clk);
    chk1("drain_next_valid", bus.res_valid, 1'b1);
    repeat (2) @(posedge clk);

    // Reset mid-stall: result dropped, pointer back to PRIO_INIT
    #1;
    bus.res_ready = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_imm = 16'h1111; bus.req0_eop = 2'b00;
    @(negedge clk);
    @(posedge clk); #1;
    bus.req0_imm = 16'h2222;
    @(negedge clk);
    chk1("prerst_valid", bus.res_valid, 1'b1);
    #2;
    reset = 1'b0;
    bus.res_ready = 1'b1;
    #1;
    chk1("arst_valid", bus.res_valid, 1'b0);
    chk("arst_data", bus.res_data, 32'h0);
    chk1("arst_ready0", bus.req0_ready, 1'b0);
    @(posedge clk); #1;
    chk1("rsthold_ready0", bus.req0_ready, 1'b0);
    chk1("rsthold_valid", bus.res_valid, 1'b0);
    bus.req0_imm = 16'h0101; bus.req0_eop = 2'b00;
    bus.req1_valid = 1'b1; bus.req1_imm = 16'h0202; bus.req1_eop = 2'b01;
    reset = 1'b1;
    @(negedge clk);
    chk1("prio_ready0", bus.req0_ready, 1'b1);
    chk1("prio_ready1", bus.req1_ready, 1'b0);
    expq.push_back({1'b0, 32'h00000101});
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    @(negedge clk);
    chk1("prio_next_ready1", bus.req1_ready, 1'b1);
    expq.push_back({1'b1, 32'h00000202});
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    repeat (2) @(negedge clk);

`ifdef EXT_ARB_STATS_EN
    @(posedge clk); #1;
    stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    @(negedge clk);
    chk("clr_g0", 32'(stat_grant0), 32'd0);
    chk("clr_g1", 32'(stat_grant1), 32'd0);
    chk("clr_stall", 32'(stat_stall), 32'd0);
    for (int n = 1; n <= 5; n++) send(1'b0, 16'(n), 2'b01, 32'(n));
    chk("sat_g0", 32'(stat_grant0), 32'd3);
    chk("sat_g1", 32'(stat_grant1), 32'd0);
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_imm = 16'habcd; bus.req0_eop = 2'b01;
    expq.push_back({1'b0, 32'h0000abcd});
    @(negedge clk);
    chk1("stat_stall_fire", bus.req0_ready, 1'b1);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.res_ready = 1'b1;
    @(negedge clk);
    chk("stall_cnt", 32'(stat_stall), 32'd2);
    @(posedge clk); #1;
    stat_clr = 1'b1;
    bus.req1_valid = 1'b1; bus.req1_imm = 16'h0005; bus.req1_eop = 2'b00;
    expq.push_back({1'b1, 32'h00000005});
    @(negedge clk);
    chk1("clr_fire", bus.req1_ready, 1'b1);
    @(posedge clk); #1;
    stat_clr = 1'b0;
    bus.req1_valid = 1'b0;
    @(negedge clk);
    chk("clrwin_g0", 32'(stat_grant0), 32'd0);
    chk("clrwin_g1", 32'(stat_grant1), 32'd0);
    chk("clrwin_stall", 32'(stat_stall), 32'd0);
`endif

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(expq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
